// File: rtl/dp_pkg.sv
// dp_pkg: instruction field positions, FSM states and widths shared by the datapath unit.
package dp_pkg;
  localparam int OPC_W   = 4;
  localparam int REG_AW  = 3;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS1_MSB = 11;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 8;
  localparam int RS2_LSB = 6;
  localparam int WS_MSB  = 5;
  localparam int WS_LSB  = 3;
  localparam int OFF_MSB = 5;
  localparam int OFF_LSB = 0;
  localparam int JMP_MSB = 11;
  localparam int JMP_LSB = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB} state_t;
endpackage

// File: rtl/dp_regbank.sv
// dp_regbank: per-context register banks with one write port, two sampled read ports and a debug read port.
module dp_regbank
  import dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int THREADS = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter int TID_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [TID_W-1:0]  wtid,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [TID_W-1:0]  rtid,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [TID_W-1:0]  dbg_tid,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int N = (2 ** TID_W) * 8;
  localparam logic [TID_W-1:0] TMASK = TID_W'(THREADS - 1);
  logic [DATA_W-1:0] regs [N];
  function automatic logic [TID_W+REG_AW-1:0] idx(input logic [TID_W-1:0] t, input logic [REG_AW-1:0] a);
    return {t & TMASK, a};
  endfunction
  // R0 stays at its reset value of 0 because writes to it are dropped, so reads need no forcing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      if (we && !(ZERO_R0 && waddr == '0)) regs[idx(wtid, waddr)] <= wdata;
      if (re) begin
        rd1 <= regs[idx(rtid, ra1)];
        rd2 <= regs[idx(rtid, ra2)];
      end
    end
  end
  assign dbg_data = regs[idx(dbg_tid, dbg_addr)];
endmodule

// File: rtl/mt_datapath_unit.sv
// mt_datapath_unit: multi-context decode/issue/write-back unit with valid/ready handshakes and a retire counter.
module mt_datapath_unit
  import dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int THREADS = 2,
  parameter bit ZERO_R0 = 1'b1,
  localparam int TID_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [15:0]       inst,
  input  logic [TID_W-1:0]  inst_tid,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [TID_W-1:0]  op_tid,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [5:0]        offset,
  output logic [DATA_W-1:0] offset_sx,
  output logic [11:0]       offset_jump,
  input  logic              wb_valid,
  input  logic              wb_en,
  input  logic              wb_is_load,
  input  logic [DATA_W-1:0] wb_data,
  output logic              retire,
  output logic [31:0]       retire_cnt,
  output logic              wb_err,
  input  logic [TID_W-1:0]  dbg_tid,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_t      state;
  logic [15:0] ir;
  logic        accept;
  logic        wb_fire;
  assign inst_ready  = state == IDLE;
  assign accept      = inst_ready && inst_valid;
  assign wb_fire     = state == WAIT_WB && wb_valid;
  assign opcode      = ir[OPC_MSB:OPC_LSB];
  assign offset      = ir[OFF_MSB:OFF_LSB];
  assign offset_sx   = {{(DATA_W - 6){ir[OFF_MSB]}}, ir[OFF_MSB:OFF_LSB]};
  assign offset_jump = ir[JMP_MSB:JMP_LSB];
  // a wb_valid arriving in the op-handshake cycle is still in ISSUE, so it counts as early
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ir         <= '0;
      op_tid     <= '0;
      op_valid   <= 1'b0;
      retire     <= 1'b0;
      retire_cnt <= '0;
      wb_err     <= 1'b0;
    end else begin
      retire <= wb_fire;
      if (wb_valid && state != WAIT_WB) wb_err <= 1'b1;
      if (wb_fire) retire_cnt <= retire_cnt + 32'd1;
      if (accept) begin
        ir       <= inst;
        op_tid   <= inst_tid;
        op_valid <= 1'b1;
        state    <= ISSUE;
      end
      if (state == ISSUE && op_ready) begin
        op_valid <= 1'b0;
        state    <= WAIT_WB;
      end
      if (wb_fire) state <= IDLE;
    end
  end
  dp_regbank #(
    .DATA_W (DATA_W),
    .THREADS(THREADS),
    .ZERO_R0(ZERO_R0),
    .TID_W  (TID_W)
  ) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_fire && wb_en),
    .wtid    (op_tid),
    .waddr   (wb_is_load ? ir[RS2_MSB:RS2_LSB] : ir[WS_MSB:WS_LSB]),
    .wdata   (wb_data),
    .re      (accept),
    .rtid    (inst_tid),
    .ra1     (inst[RS1_MSB:RS1_LSB]),
    .ra2     (inst[RS2_MSB:RS2_LSB]),
    .rd1     (rd1),
    .rd2     (rd2),
    .dbg_tid (dbg_tid),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );
endmodule

// File: tb/tb_mt_datapath_unit.sv
// tb_mt_datapath_unit: directed vectors with hand-computed expectations for mt_datapath_unit.
module tb_mt_datapath_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [15:0] inst = '0;
  logic [0:0]  inst_tid = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [3:0]  opcode;
  logic [0:0]  op_tid;
  logic [15:0] rd1, rd2;
  logic [5:0]  offset;
  logic [15:0] offset_sx;
  logic [11:0] offset_jump;
  logic        wb_valid = 1'b0;
  logic        wb_en = 1'b0;
  logic        wb_is_load = 1'b0;
  logic [15:0] wb_data = '0;
  logic        retire;
  logic [31:0] retire_cnt;
  logic        wb_err;
  logic [0:0]  dbg_tid = '0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  int n_chk = 0;
  int n_pass = 0;

  mt_datapath_unit #(.DATA_W(16), .THREADS(2), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_tid(inst_tid), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .op_tid(op_tid), .rd1(rd1), .rd2(rd2), .offset(offset),
    .offset_sx(offset_sx), .offset_jump(offset_jump), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_is_load(wb_is_load), .wb_data(wb_data), .retire(retire),
    .retire_cnt(retire_cnt), .wb_err(wb_err), .dbg_tid(dbg_tid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string tag, input logic [0:0] t, input logic [2:0] a, input logic [15:0] exp);
    dbg_tid  = t;
    dbg_addr = a;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic accept(input logic [0:0] t, input logic [15:0] i);
    inst_valid = 1'b1;
    inst_tid   = t;
    inst       = i;
    tick();
    inst_valid = 1'b0;
    inst       = '0;
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic wb(input logic en, input logic ld, input logic [15:0] d);
    wb_valid   = 1'b1;
    wb_en      = en;
    wb_is_load = ld;
    wb_data    = d;
    tick();
    wb_valid = 1'b0;
    wb_en    = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 8; a++) rdchk("reset_reg", t[0:0], a[2:0], 16'h0);
    chk("reset_cnt", retire_cnt, 32'd0);
    chk("reset_ready", {31'd0, inst_ready}, 32'd1);
    chk("reset_opv", {31'd0, op_valid}, 32'd0);
    chk("reset_err", {31'd0, wb_err}, 32'd0);

    accept(1'b0, 16'h0A98);
    chk("t2_opv", {31'd0, op_valid}, 32'd1);
    chk("t2_ready", {31'd0, inst_ready}, 32'd0);
    handshake();
    chk("t2_opv_drop", {31'd0, op_valid}, 32'd0);
    wb(1'b1, 1'b0, 16'h1234);
    chk("t2_retire", {31'd0, retire}, 32'd1);
    chk("t2_cnt", retire_cnt, 32'd1);
    rdchk("t2_r03", 1'b0, 3'd3, 16'h1234);
    rdchk("t2_r13", 1'b1, 3'd3, 16'h0);
    tick();
    chk("t2_retire_pulse", {31'd0, retire}, 32'd0);
    chk("t2_ready_back", {31'd0, inst_ready}, 32'd1);

    accept(1'b1, 16'h1100);
    handshake();
    wb(1'b1, 1'b1, 16'hBEEF);
    rdchk("t3_r14", 1'b1, 3'd4, 16'hBEEF);
    rdchk("t3_r04", 1'b0, 3'd4, 16'h0);
    accept(1'b1, 16'h2800);
    chk("t3_rd1_t1", {16'h0, rd1}, 32'h0000BEEF);
    chk("t3_optid", {31'd0, op_tid}, 32'd1);
    chk("t3_opc", {28'd0, opcode}, 32'd2);
    handshake();
    wb(1'b0, 1'b0, 16'h9999);
    rdchk("t3_nowrite", 1'b1, 3'd0, 16'h0);
    accept(1'b0, 16'h2800);
    chk("t3_rd1_t0", {16'h0, rd1}, 32'd0);
    handshake();
    wb(1'b0, 1'b0, 16'h0);
    chk("t3_cnt", retire_cnt, 32'd4);

    accept(1'b0, 16'h36C8);
    for (int c = 0; c < 5; c++) begin
      chk("t4_opv", {31'd0, op_valid}, 32'd1);
      chk("t4_rd1", {16'h0, rd1}, 32'h00001234);
      chk("t4_rd2", {16'h0, rd2}, 32'h00001234);
      chk("t4_opc", {28'd0, opcode}, 32'd3);
      chk("t4_ready", {31'd0, inst_ready}, 32'd0);
      tick();
    end
    handshake();
    chk("t4_opv_drop", {31'd0, op_valid}, 32'd0);
    chk("t4_ready_wait", {31'd0, inst_ready}, 32'd0);
    wb(1'b1, 1'b0, 16'h5555);
    rdchk("t4_r01", 1'b0, 3'd1, 16'h5555);

    accept(1'b0, 16'h5000);
    handshake();
    wb(1'b1, 1'b0, 16'hFFFF);
    rdchk("t5_r00", 1'b0, 3'd0, 16'h0);
    accept(1'b0, 16'h4021);
    chk("t5_rd1_r0", {16'h0, rd1}, 32'd0);
    chk("t5_off", {26'd0, offset}, 32'h21);
    chk("t5_offsx", {16'h0, offset_sx}, 32'h0000FFE1);
    chk("t5_offjmp", {20'd0, offset_jump}, 32'h021);
    handshake();
    wb(1'b0, 1'b0, 16'h0);
    chk("t5_cnt", retire_cnt, 32'd7);
    chk("t5_err_clean", {31'd0, wb_err}, 32'd0);

    wb(1'b1, 1'b0, 16'hAAAA);
    chk("t6_err", {31'd0, wb_err}, 32'd1);
    chk("t6_noretire", {31'd0, retire}, 32'd0);
    chk("t6_cnt", retire_cnt, 32'd7);
    rdchk("t6_r04", 1'b0, 3'd4, 16'h0);
    rdchk("t6_r03", 1'b0, 3'd3, 16'h1234);

    accept(1'b1, 16'h0A98);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_opv", {31'd0, op_valid}, 32'd0);
    chk("rst_ready", {31'd0, inst_ready}, 32'd1);
    chk("rst_err", {31'd0, wb_err}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    rdchk("rst_r03", 1'b0, 3'd3, 16'h0);

    accept(1'b1, 16'h0008);
    op_ready = 1'b1;
    wb_valid = 1'b1;
    wb_en    = 1'b1;
    wb_data  = 16'h7777;
    tick();
    op_ready = 1'b0;
    wb_valid = 1'b0;
    wb_en    = 1'b0;
    chk("early_err", {31'd0, wb_err}, 32'd1);
    chk("early_opv", {31'd0, op_valid}, 32'd0);
    chk("early_ready", {31'd0, inst_ready}, 32'd0);
    rdchk("early_r11", 1'b1, 3'd1, 16'h0);
    wb(1'b1, 1'b0, 16'h0042);
    chk("early_retire", {31'd0, retire}, 32'd1);
    chk("early_cnt", retire_cnt, 32'd1);
    rdchk("early_r11_wb", 1'b1, 3'd1, 16'h0042);
    rdchk("early_r01", 1'b0, 3'd1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mt_datapath_unit.md
Name: mt_datapath_unit

Overview:
Parametrised successor of the single-context datapath: decodes 16-bit instructions, reads operands from a register file, issues them to the ALU/memory stage and commits the write-back result. It adds THREADS independent register banks (one per hardware context) and generic DATA_W. Explicit valid/ready handshakes replace edge-triggered flags, and a retire counter is added. It sits between instruction fetch (upstream) and ALU/Data_Memory (downstream).

Parameters:
DATA_W, 16, register and operand width (>=16)
THREADS, 2, number of register banks / hardware contexts (power of 2, >=1)
ZERO_R0, 1, 1: R0 of every bank reads 0 and ignores writes; 0: R0 is an ordinary register
TID_W, $clog2(THREADS) (min 1), thread-id width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
inst_valid  in  1  instruction offered
inst_ready  out  1  block can accept an instruction
inst  in  16  instruction: [15:12] opcode, [11:9] rs1, [8:6] rs2, [5:3] ws, [5:0] offset, [11:0] jump offset
inst_tid  in  TID_W  context of offered instruction
op_valid  out  1  decoded operation valid to ALU stage
op_ready  in  1  ALU stage accepts operation
opcode  out  4  decoded opcode
op_tid  out  TID_W  context of issued operation
rd1  out  DATA_W  R[tid][rs1]
rd2  out  DATA_W  R[tid][rs2]
offset  out  6  raw inst[5:0]
offset_sx  out  DATA_W  inst[5:0] sign-extended
offset_jump  out  12  inst[11:0]
wb_valid  in  1  write-back/completion from ALU or memory (single-cycle pulse)
wb_en  in  1  1: write wb_data; 0: complete without write (store, branch)
wb_is_load  in  1  1: destination rs2; 0: destination ws
wb_data  in  DATA_W  write-back value
retire  out  1  one-cycle pulse when an instruction completes (fetch-next request)
retire_cnt  out  32  completed-instruction count, wraps 2^32-1 -> 0
wb_err  out  1  sticky: wb_valid seen outside WAIT_WB
dbg_tid  in  TID_W  debug read context
dbg_addr  in  3  debug read register
dbg_data  out  DATA_W  combinational R[dbg_tid][dbg_addr]

Behaviour:
- Reset (rst_n=0 at posedge): all THREADS×8 registers = 0; state IDLE; op_valid, retire, wb_err = 0; retire_cnt = 0; opcode, op_tid, rd1, rd2, offset fields = 0. Aborts any in-flight instruction, no write.
- FSM: IDLE -> ISSUE -> WAIT_WB -> IDLE; one instruction outstanding.
- IDLE: inst_ready=1. On inst_valid at edge N: latch fields and tid; rd1/rd2 sampled from bank inst_tid at edge N (R0 forced 0 if ZERO_R0); go ISSUE. op_valid=1 from cycle N+1.
- ISSUE: inst_ready=0; op_valid and all op outputs held stable until op_ready=1; on op_valid&&op_ready -> WAIT_WB, op_valid=0 next cycle.
- WAIT_WB: on wb_valid: if wb_en, write wb_data to R[op_tid][wb_is_load ? rs2 : ws] (suppressed if dest=0 and ZERO_R0=1); retire=1 next cycle; retire_cnt+1; -> IDLE. A write at edge M is visible to an instruction accepted at edge M+1 or later (no bypass needed).
- wb_valid in IDLE or ISSUE: ignored, wb_err set (cleared only by reset).
- wb_valid in the same cycle as the op handshake: treated as early; it is ignored and sets wb_err.
- Minimum throughput: one instruction per 3 cycles (accept, issue handshake, wb).
- Banks are isolated: a write for tid t never alters other banks.
- dbg_data reflects writes the cycle after the write edge.

Decomposition:
- dp_pkg: field bit positions (OPC_MSB/LSB, RS1, RS2, WS, OFF, JMP), state enum {IDLE, ISSUE, WAIT_WB}, OPC_W=4, REG_AW=3.
- Sub-module dp_regbank: THREADS×8×DATA_W, one synchronous write port, two synchronous-sampled read ports plus one combinational debug read port, ZERO_R0 handling, synchronous clear on reset.

Test Plan:
- Reset then dbg read every tid/addr -> all 0; retire_cnt=0; inst_ready=1.
- tid0 inst 0x0A98 (rs1=5, rs2=2, ws=3), op_ready=1, then wb_valid with wb_en=1, wb_is_load=0, wb_data=0x1234 -> R[0][3]=0x1234, R[1][3]=0, single retire pulse, retire_cnt=1.
- Load with wb_is_load=1, rs2=4, data 0xBEEF on tid1; next inst on tid1 with rs1=4 -> rd1=0xBEEF; same inst on tid0 -> rd1=0.
- Hold op_ready=0 for 5 cycles -> op_valid and rd1/rd2/opcode stable and inst_ready=0 throughout; op_ready=1 -> WAIT_WB.
- ZERO_R0=1: wb to ws=0 with 0xFFFF -> R0 reads 0; offset inst[5:0]=6'b100001 -> offset_sx=0xFFE1.
- wb_valid in IDLE -> wb_err=1 and no register changes; rst_n=0 mid-ISSUE -> op_valid=0, state IDLE, wb_err=0.
